// File: rtl/pe_incha_double_ibuffer.sv
// pe_incha_double_ibuffer: packs a serial pixel stream into even/odd lane pairs,
// with an odd final pixel of a frame emitted alone on lane b.
module pe_incha_double_ibuffer #(
    parameter int DATA_WIDTH = 8,
    parameter int IN_WIDTH   = 513,
    parameter int IN_HEIGHT  = 257
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data_a,
    output logic [DATA_WIDTH-1:0] o_data_b,
    output logic                  o_valid,
    output logic                  o_odd,
    output logic                  o_last,
    input  logic                  i_ready
);
    localparam int PIXELS = IN_WIDTH * IN_HEIGHT;
    localparam int CW     = PIXELS > 1 ? $clog2(PIXELS) : 1;
    logic [CW-1:0]         pix_cnt;
    logic                  phase;
    logic [DATA_WIDTH-1:0] hold;
    logic                  last_pix, hold_free, accept, load;
    assign last_pix  = pix_cnt == CW'(PIXELS - 1);
    assign hold_free = !phase && !last_pix;
    assign o_ready   = hold_free || !o_valid || i_ready;
    assign accept    = i_valid && o_ready;
    // a pixel that completes a pair, or a lone final pixel, goes straight to the output register
    assign load      = accept && !hold_free;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt  <= '0;
            phase    <= 1'b0;
            o_valid  <= 1'b0;
            o_odd    <= 1'b0;
            o_last   <= 1'b0;
            o_data_a <= '0;
            o_data_b <= '0;
        end else begin
            if (accept)
                pix_cnt <= last_pix ? '0 : pix_cnt + 1'b1;
            if (accept && hold_free)
                phase <= 1'b1;
            if (load) begin
                o_data_a <= phase ? hold : '0;
                o_data_b <= i_data;
                o_valid  <= 1'b1;
                o_odd    <= !phase;
                o_last   <= last_pix;
                phase    <= 1'b0;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end
    always_ff @(posedge clk)
        if (accept && hold_free)
            hold <= i_data;
endmodule
